// File: rtl/layer_bridge.sv
`timescale 1ns/1ps
// layer_bridge
// Captures a full parallel activation vector from one layer into a two-slot
// (ping/pong) buffer and streams it to the next layer as LANES elements per
// beat, with ready/valid backpressure, an optional fused ReLU applied at
// capture, a last-beat marker and dropped-vector accounting.
//
// Ports:
//   clk         clock
//   rst         asynchronous reset, active-high
//   i_valid     zin holds a valid vector this cycle
//   zin         unpacked input vector, NUM_NODES signed elements
//   i_relu      fused ReLU enable, sampled at capture
//   i_ready     a buffer slot is free (registered-state decode only)
//   o_valid     o_data holds a valid beat
//   o_ready     downstream accepts the beat
//   o_data      LANES elements; lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//   o_last      current beat is the final beat of its vector
//   o_overflow  one-cycle pulse after a vector is dropped
//   drop_count  saturating count of dropped vectors
module layer_bridge #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_NODES  = 32,
  parameter int LANES      = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  input  logic [DATA_WIDTH-1:0]       zin [NUM_NODES],
  input  logic                        i_relu,
  output logic                        i_ready,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [LANES*DATA_WIDTH-1:0] o_data,
  output logic                        o_last,
  output logic                        o_overflow,
  output logic [CNT_WIDTH-1:0]        drop_count
);

  localparam int BEATS  = NUM_NODES / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t              occ;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [BEAT_W-1:0] beat;

  // Ping/pong storage; data registers carry no reset, o_data is gated by o_valid.
  logic [DATA_WIDTH-1:0] mem [2][NUM_NODES];

  logic capture;
  logic drop;
  logic xfer;
  logic last_xfer;

  function automatic logic [DATA_WIDTH-1:0] relu_clamp(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic                         en
  );
    if (en && (x < 0)) return '0;
    return x;
  endfunction

  function automatic logic [IDX_W-1:0] elem_idx(
    input logic [BEAT_W-1:0] b,
    input int                j
  );
    return IDX_W'(int'(b) * LANES + j);
  endfunction

  assign i_ready   = (occ != FULL);
  assign o_valid   = (occ != EMPTY);
  assign o_last    = o_valid && (beat == BEAT_LAST);
  assign capture   = i_valid && i_ready;
  assign drop      = i_valid && !i_ready;
  assign xfer      = o_valid && o_ready;
  assign last_xfer = xfer && (beat == BEAT_LAST);

  // ---- capture stage: vector into slot[wr_ptr] ----
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NUM_NODES; i++) begin
        mem[wr_ptr][IDX_W'(i)] <= relu_clamp(zin[IDX_W'(i)], i_relu);
      end
    end
  end

  // ---- control: occupancy, pointers, beat counter, drop accounting ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= EMPTY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      beat       <= '0;
      o_overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      if (capture) wr_ptr <= ~wr_ptr;
      if (last_xfer) rd_ptr <= ~rd_ptr;
      if (xfer) beat <= (beat == BEAT_LAST) ? '0 : beat + 1'b1;

      // A capture and a final-beat retire in the same cycle cancel out.
      unique case (occ)
        EMPTY: if (capture) occ <= ONE;
        ONE: begin
          if (capture && !last_xfer)      occ <= FULL;
          else if (!capture && last_xfer) occ <= EMPTY;
        end
        FULL:    if (last_xfer) occ <= ONE;
        default: occ <= EMPTY;
      endcase

      o_overflow <= drop;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end

  // ---- output stage: beat select from registered storage ----
  always_comb begin
    o_data = '0;
    if (o_valid) begin
      for (int j = 0; j < LANES; j++) begin
        o_data[j*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr][elem_idx(beat, j)];
      end
    end
  end

endmodule

// File: tb/tb_layer_bridge.sv
`timescale 1ns/1ps
module tb_layer_bridge;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [7:0]  zin [4];
  logic        i_relu;
  logic        o_ready;

  logic        i_ready1, o_valid1, o_last1, o_overflow1;
  logic [7:0]  o_data1;
  logic [7:0]  drop_count1;
  logic        i_ready2, o_valid2, o_last2, o_overflow2;
  logic [15:0] o_data2;
  logic [7:0]  drop_count2;

  int total = 0;
  int bad   = 0;

  layer_bridge #(.DATA_WIDTH(8), .NUM_NODES(4), .LANES(1), .CNT_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .zin(zin), .i_relu(i_relu),
    .i_ready(i_ready1), .o_valid(o_valid1), .o_ready(o_ready), .o_data(o_data1),
    .o_last(o_last1), .o_overflow(o_overflow1), .drop_count(drop_count1)
  );

  layer_bridge #(.DATA_WIDTH(8), .NUM_NODES(4), .LANES(2), .CNT_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .zin(zin), .i_relu(i_relu),
    .i_ready(i_ready2), .o_valid(o_valid2), .o_ready(o_ready), .o_data(o_data2),
    .o_last(o_last2), .o_overflow(o_overflow2), .drop_count(drop_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance k: an in-order list of up to two stored vectors (element i
  // in bits [8i+:8]), the index of the beat on offer, and drop bookkeeping.
  logic [31:0] mv [2][2];
  int          mn [2];
  int          mb [2];
  int          mc [2];
  bit          mo [2];

  function automatic logic [31:0] in_vec();
    logic [31:0] v;
    logic [7:0]  e;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      e = zin[i];
      if (i_relu && $signed(e) < 0) e = 8'h00;
      v[8*i +: 8] = e;
    end
    return v;
  endfunction

  task automatic model_step(input int k);
    int  beats;
    bit  cap;
    bit  drp;
    beats = (k == 0) ? 4 : 2;
    cap = i_valid && (mn[k] < 2);
    drp = i_valid && (mn[k] == 2);
    if (mn[k] > 0 && o_ready) begin
      if (mb[k] == beats - 1) begin
        mv[k][0] = mv[k][1];
        mn[k]--;
        mb[k] = 0;
      end else begin
        mb[k]++;
      end
    end
    if (cap) begin
      mv[k][mn[k]] = in_vec();
      mn[k]++;
    end
    mo[k] = drp;
    if (drp && mc[k] < 255) mc[k]++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mn[k] = 0; mb[k] = 0; mc[k] = 0; mo[k] = 1'b0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  function automatic logic [15:0] exp_data(input int k);
    int l;
    if (mn[k] == 0) return 16'h0;
    l = (k == 0) ? 1 : 2;
    return 16'((mv[k][0] >> (mb[k] * l * 8)) & ((l == 1) ? 32'hFF : 32'hFFFF));
  endfunction

  function automatic logic exp_last(input int k);
    return (mn[k] > 0) && (mb[k] == ((k == 0) ? 3 : 1));
  endfunction

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("m1_valid", 32'(o_valid1), 32'(mn[0] > 0));
      chk("m1_data",  32'(o_data1),  32'(exp_data(0)));
      chk("m1_last",  32'(o_last1),  32'(exp_last(0)));
      chk("m1_ready", 32'(i_ready1), 32'(mn[0] < 2));
      chk("m1_ovf",   32'(o_overflow1), 32'(mo[0]));
      chk("m1_drops", 32'(drop_count1), 32'(mc[0]));
      chk("m2_valid", 32'(o_valid2), 32'(mn[1] > 0));
      chk("m2_data",  32'(o_data2),  32'(exp_data(1)));
      chk("m2_last",  32'(o_last2),  32'(exp_last(1)));
      chk("m2_ready", 32'(i_ready2), 32'(mn[1] < 2));
      chk("m2_ovf",   32'(o_overflow2), 32'(mo[1]));
      chk("m2_drops", 32'(drop_count2), 32'(mc[1]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_vec(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    zin[0] = a; zin[1] = b; zin[2] = c; zin[3] = d;
  endtask

  logic [7:0] pd;
  logic       pv;
  logic       pl;
  logic       pr;
  logic [7:0] relu_exp [4];

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_relu = 1'b0; o_ready = 1'b0;
    set_vec(8'h0, 8'h0, 8'h0, 8'h0);
    tick();
    chk("rst_valid", 32'(o_valid1), 32'd0);
    chk("rst_ready", 32'(i_ready1), 32'd1);
    chk("rst_data",  32'(o_data1),  32'd0);
    chk("rst_last",  32'(o_last1),  32'd0);
    chk("rst_ovf",   32'(o_overflow1), 32'd0);
    chk("rst_drops", 32'(drop_count1), 32'd0);
    rst = 1'b0;
    tick();

    // 1: plain stream
    o_ready = 1'b1;
    set_vec(8'd1, 8'd2, 8'd3, 8'd4);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      chk("t1_data", 32'(o_data1), 32'(b));
      chk("t1_last", 32'(o_last1), 32'(b == 4));
      if (b == 1) begin
        chk("t4_beat0", 32'(o_data2), 32'h0201);
        chk("t4_last0", 32'(o_last2), 32'd0);
      end
      if (b == 2) begin
        chk("t4_beat1", 32'(o_data2), 32'h0403);
        chk("t4_last1", 32'(o_last2), 32'd1);
      end
      tick();
    end
    chk("t1_idle_valid", 32'(o_valid1), 32'd0);
    chk("t1_idle_ready", 32'(i_ready1), 32'd1);

    // 2: fused ReLU
    set_vec(8'hFF, 8'h05, 8'h80, 8'h7F);
    i_relu = 1'b1; i_valid = 1'b1;
    tick();
    i_valid = 1'b0; i_relu = 1'b0;
    relu_exp[0] = 8'h00; relu_exp[1] = 8'h05; relu_exp[2] = 8'h00; relu_exp[3] = 8'h7F;
    for (int b = 0; b < 4; b++) begin
      chk("t2_relu", 32'(o_data1), 32'(relu_exp[b]));
      tick();
    end

    // 3: backpressure, fill both slots, drop a third vector
    o_ready = 1'b0;
    set_vec(8'd1, 8'd2, 8'd3, 8'd4); i_valid = 1'b1;
    tick();
    set_vec(8'd5, 8'd6, 8'd7, 8'd8);
    tick();
    chk("t3_full_ready", 32'(i_ready1), 32'd0);
    set_vec(8'd9, 8'd10, 8'd11, 8'd12);
    tick();
    i_valid = 1'b0;
    chk("t3_ovf_pulse", 32'(o_overflow1), 32'd1);
    chk("t3_drops",     32'(drop_count1), 32'd1);
    tick();
    chk("t3_ovf_clear", 32'(o_overflow1), 32'd0);
    chk("t3_held",      32'(o_data1),     32'd1);
    o_ready = 1'b1;
    for (int b = 1; b <= 8; b++) begin
      chk("t3_data", 32'(o_data1), 32'(b));
      chk("t3_last", 32'(o_last1), 32'(b == 4 || b == 8));
      tick();
    end
    chk("t3_no_c", 32'(o_valid1), 32'd0);

    // 5: capture in the same cycle as the final-beat retire, then random stalls
    set_vec(8'd1, 8'd2, 8'd3, 8'd4); i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick(); tick(); tick();
    chk("t5_a_last", 32'(o_data1), 32'd4);
    set_vec(8'h11, 8'h12, 8'h13, 8'h14); i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("t5_b_beat0", 32'(o_data1),  32'h11);
    chk("t5_b_valid", 32'(o_valid1), 32'd1);
    chk("t5_one",     32'(i_ready1), 32'd1);
    for (int n = 0; n < 24; n++) begin
      pd = o_data1; pv = o_valid1; pl = o_last1;
      o_ready = 1'($urandom_range(0, 1));
      pr = o_ready;
      tick();
      if (!pr && pv) begin
        chk("t5_stall_data",  32'(o_data1),  32'(pd));
        chk("t5_stall_last",  32'(o_last1),  32'(pl));
        chk("t5_stall_valid", 32'(o_valid1), 32'd1);
      end
    end
    o_ready = 1'b1;
    repeat (6) tick();
    chk("t5_drained", 32'(o_valid1), 32'd0);

    // 6: asynchronous reset mid-stream
    set_vec(8'd1, 8'd2, 8'd3, 8'd4); i_valid = 1'b1;
    tick();
    set_vec(8'd5, 8'd6, 8'd7, 8'd8);
    tick();
    i_valid = 1'b0;
    tick();
    chk("t6_pre", 32'(o_data1), 32'd3);
    rst = 1'b1;
    #1;
    chk("t6_valid", 32'(o_valid1),    32'd0);
    chk("t6_ready", 32'(i_ready1),    32'd1);
    chk("t6_drops", 32'(drop_count1), 32'd0);
    chk("t6_data",  32'(o_data1),     32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle", 32'(o_valid1), 32'd0);
    set_vec(8'h21, 8'h22, 8'h23, 8'h24); i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      chk("t6_restream", 32'(o_data1), 32'(8'h21 + b));
      tick();
    end
    chk("t6_end", 32'(o_valid1), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_bridge.md
Name: layer_bridge

Overview:
Parametrised successor to the inter-layer serializer in the accelerator core. It captures a full parallel activation vector from one layer and streams it to the next layer as LANES elements per beat. It adds double buffering, ready/valid backpressure, an optional fused ReLU, a last-beat marker and overflow accounting. It sits between a ReLU/linear layer's parallel output and the next linear layer's serial input.

Parameters:
DATA_WIDTH, 16, element width; elements are signed two's complement.
NUM_NODES, 32, elements per vector; must be a multiple of LANES.
LANES, 1, elements per output beat; BEATS = NUM_NODES/LANES.
CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_valid  in  1  zin holds a valid vector this cycle
zin  in  DATA_WIDTH x [NUM_NODES]  unpacked input vector
i_relu  in  1  fused ReLU enable, sampled at capture
i_ready  out  1  a buffer slot is free
o_valid  out  1  o_data holds a valid beat
o_ready  in  1  downstream accepts the beat
o_data  out  LANES*DATA_WIDTH  lane j occupies bits [j*DATA_WIDTH +: DATA_WIDTH]
o_last  out  1  current beat is the final beat of its vector
o_overflow  out  1  one-cycle pulse when a vector is dropped
drop_count  out  CNT_WIDTH  number of dropped vectors, saturating

Behaviour:
- Reset: one clock; rst is asynchronous and active-high.
- Reset values: occupancy=0, wr_ptr=0, rd_ptr=0, beat=0. o_valid=0, o_last=0, o_data=0, o_overflow=0, drop_count=0, i_ready=1.
- Reset asserted mid-stream discards all buffered data immediately, with no flush.
- Storage: two slots (ping/pong), each NUM_NODES x DATA_WIDTH registers.
- Occupancy states:
  - EMPTY: 0 slots full.
  - ONE: 1 slot full.
  - FULL: 2 slots full.
- i_ready = (occupancy != FULL). It is decoded from registered state only and never combinationally from o_ready.
- Capture: on i_valid && i_ready:
  - slot[wr_ptr] <= zin, element-wise.
  - If i_relu=1, any element with MSB=1 is stored as 0.
  - wr_ptr toggles and occupancy increments.
- Drop: on i_valid && !i_ready:
  - The vector is discarded.
  - o_overflow=1 on the next cycle, for exactly one cycle.
  - drop_count increments, saturating at 2^CNT_WIDTH-1.
- Output validity: o_valid = (occupancy != EMPTY).
- Output data: lane j of o_data = slot[rd_ptr][beat*LANES + j]. o_data is driven from registered storage; when o_valid=0, o_data=0.
- Latency: a vector captured at edge N presents beat 0 after edge N, i.e. one cycle of latency.
- Beat handshake: a beat transfers on o_valid && o_ready.
  - beat increments on each transfer.
  - o_valid, o_data and o_last must hold steady while o_ready=0.
- o_last = o_valid && (beat == BEATS-1).
- Last-beat transfer: beat <= 0, rd_ptr toggles and occupancy decrements. The next slot, if full, is presented on the following cycle with no bubble.
- Simultaneous capture and last-beat transfer in the same cycle: occupancy is unchanged, and both pointers and the slot write update.
- FULL with a same-cycle last-beat transfer: i_ready is still 0 and an incoming vector is dropped. There is no pass-through.
- Vectors are emitted strictly in capture order.
- Width rules:
  - beat counter width = max(1, $clog2(BEATS)).
  - BEATS=1 is legal: every beat is last.
  - No arithmetic is performed on data other than the ReLU clamp.

Test Plan (DATA_WIDTH=8, NUM_NODES=4, LANES=1 unless noted):
1. Capture {1,2,3,4} with o_ready=1 and i_relu=0 -> beats 1,2,3,4 on the four cycles after capture; o_last only with 4; then o_valid=0 and i_ready=1.
2. i_relu=1, zin={0xFF,0x05,0x80,0x7F} -> beats 0x00,0x05,0x00,0x7F.
3. o_ready=0, capture A={1,2,3,4} then B={5,6,7,8} -> i_ready=0. Third vector C is offered -> o_overflow pulses once and drop_count=1. Raise o_ready -> 1..4 then 5..8 back-to-back with o_last on 4 and 8; C never appears.
4. LANES=2, zin={1,2,3,4} -> beat0 o_data={lane1=2, lane0=1} with o_last=0; beat1 {4,3} with o_last=1.
5. Occupancy ONE, last beat of A accepted in the same cycle B is captured -> B's beat 0 presented next cycle and occupancy remains ONE. Toggle o_ready randomly -> o_data stable while stalled.
6. Assert rst asynchronously after beat 2 of A, with B buffered -> o_valid=0 before the next edge, drop_count=0 and i_ready=1. A new vector after reset streams from beat 0.
